// File: rtl/vend_pkg.sv
// Shared encodings for the vending dispense scheduler: FSM states and
// actuator select values.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRIVE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic ACT_SEL_COLA = 1'b0;
    localparam logic ACT_SEL_COIN = 1'b1;

endpackage

// File: rtl/pend_cnt.sv
// Saturating up/down pending-job counter. An increment and a decrement in
// the same cycle cancel out. sat_hit flags an increment that was dropped
// because the counter was already full.
module pend_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_cnt == CNT_MAX);
    assign w_empty = (r_cnt == '0);
    assign sat_hit = inc && !dec && w_full;
    assign cnt     = r_cnt;

    // Count requests up and started jobs down, clamped at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && !dec && !w_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (dec && !inc && !w_empty) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: queues cola / change-coin requests and time-shares one
// actuator driver between the cola chute and the coin hopper. Each job is a
// timed drive pulse, a bounded wait for the sensor ack, then a cooldown gap.
// A missing ack parks the scheduler in a sticky FAULT until fault_clr.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pi_cola,
    input  logic             pi_money,
    input  logic             act_done,
    input  logic             fault_clr,
    output logic             act_en,
    output logic             act_sel,
    output logic [CNT_W-1:0] cola_pend,
    output logic [CNT_W-1:0] coin_pend,
    output logic             busy,
    output logic             fault,
    output logic             ovf
);

    // One timer serves every timed state, so it is sized for the longest load.
    localparam int TMR_MAX =
        (TIMEOUT_CYC > PULSE_CYC) ?
            ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
            ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] LD_PULSE   = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] LD_GAP     = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] LD_TIMEOUT = TMR_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nx;
    logic             r_act_en;
    logic             w_act_en_nx;
    logic             r_act_sel;
    logic             w_act_sel_nx;
    logic             r_fault;
    logic             w_fault_nx;
    logic             r_ack;
    logic             r_ovf;
    logic             w_cola_dec;
    logic             w_coin_dec;
    logic             w_start;
    logic             w_cola_sat;
    logic             w_coin_sat;
    logic [CNT_W-1:0] w_cola_cnt;
    logic [CNT_W-1:0] w_coin_cnt;

    pend_cnt #(.CNT_W(CNT_W)) u_cola_cnt (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .inc     (pi_cola),
        .dec     (w_cola_dec),
        .cnt     (w_cola_cnt),
        .sat_hit (w_cola_sat)
    );

    pend_cnt #(.CNT_W(CNT_W)) u_coin_cnt (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .inc     (pi_money),
        .dec     (w_coin_dec),
        .cnt     (w_coin_cnt),
        .sat_hit (w_coin_sat)
    );

    assign w_start = w_cola_dec | w_coin_dec;

    // Next-state, timer reload and registered-output values for the job sequencer.
    always_comb begin
        w_state_nx   = r_state;
        w_tmr_nx     = r_tmr;
        w_act_en_nx  = r_act_en;
        w_act_sel_nx = r_act_sel;
        w_fault_nx   = r_fault;
        w_cola_dec   = 1'b0;
        w_coin_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Cola always wins over change coins when both are owed.
                if (w_cola_cnt != '0) begin
                    w_state_nx   = ST_DRIVE;
                    w_tmr_nx     = LD_PULSE;
                    w_act_en_nx  = 1'b1;
                    w_act_sel_nx = ACT_SEL_COLA;
                    w_cola_dec   = 1'b1;
                end else if (w_coin_cnt != '0) begin
                    w_state_nx   = ST_DRIVE;
                    w_tmr_nx     = LD_PULSE;
                    w_act_en_nx  = 1'b1;
                    w_act_sel_nx = ACT_SEL_COIN;
                    w_coin_dec   = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (r_tmr == '0) begin
                    w_state_nx  = ST_WAIT_DONE;
                    w_tmr_nx    = LD_TIMEOUT;
                    w_act_en_nx = 1'b0;
                end else begin
                    w_tmr_nx = r_tmr - TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (r_ack) begin
                    w_state_nx = ST_GAP;
                    w_tmr_nx   = LD_GAP;
                end else if (r_tmr == '0) begin
                    w_state_nx = ST_FAULT;
                    w_fault_nx = 1'b1;
                end else begin
                    w_tmr_nx = r_tmr - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (r_tmr == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr - TMR_W'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nx = ST_IDLE;
                    w_fault_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Register state, timer and actuator outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_tmr     <= '0;
            r_act_en  <= 1'b0;
            r_act_sel <= ACT_SEL_COLA;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_tmr     <= w_tmr_nx;
            r_act_en  <= w_act_en_nx;
            r_act_sel <= w_act_sel_nx;
            r_fault   <= w_fault_nx;
        end
    end

    // Catch a sensor ack anywhere in the drive or wait window of the current job.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ack <= 1'b0;
        end else if (w_start) begin
            r_ack <= 1'b0;
        end else if ((r_state == ST_DRIVE || r_state == ST_WAIT_DONE) && act_done) begin
            r_ack <= 1'b1;
        end
    end

    // Remember any request lost to a full counter until the next reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ovf <= 1'b0;
        end else if (w_cola_sat || w_coin_sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign act_en    = r_act_en;
    assign act_sel   = r_act_sel;
    assign cola_pend = w_cola_cnt;
    assign coin_pend = w_coin_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign fault     = r_fault;
    assign ovf       = r_ovf;

endmodule
